// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================
// Package  : draw_pkg
// Summary  : shared FSM state, coordinate widths and timeout default.
// Revision : 1.0
// ============================================================
package draw_pkg;

  localparam int X_W             = 9;
  localparam int Y_W             = 8;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    ACK   = 3'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/draw_scheduler_rr_picker.sv
`default_nettype none
// ============================================================
// Module   : rr_picker
// Summary  : combinational round-robin pick, first set bit at or after ptr_i.
// Revision : 1.0
// ============================================================
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             valid_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk ptr_i, ptr_i+1, ... with wrap so non-power-of-two counts also work.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================
// Module   : draw_scheduler
// Summary  : round-robin scheduler sharing one shape drawer, with job timeout.
// Revision : 1.0
// ============================================================
module draw_scheduler
  import draw_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [X_W*N_REQ-1:0]   req_x,
  input  logic [Y_W*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   drw_start,
  output logic [X_W-1:0]         drw_x,
  output logic [Y_W-1:0]         drw_y,
  input  logic                   drw_done
);

  state_e         state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           err_q, err_d;

  logic [N_REQ-1:0] pick_onehot;
  logic             pick_valid;
  logic [GW-1:0]    pick_idx;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_onehot),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = GW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = DRIVE;
          grant_d = pick_idx;
          x_d     = req_x[int'(pick_idx)*X_W +: X_W];
          y_d     = req_y[int'(pick_idx)*Y_W +: Y_W];
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (drw_done) begin
          state_d = ACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ACK;
          err_d   = 1'b1;
        end
      end
      ACK: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = state_e'(3'bxxx);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign drw_start = (state_q == DRIVE);
  assign drw_x     = x_q;
  assign drw_y     = y_q;
  assign grant_id  = grant_q;
  assign ack       = (state_q == ACK) ? (N_REQ'(1) << grant_q) : '0;
  assign err       = (state_q == ACK) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================
// Module   : tb_draw_scheduler
// Summary  : scoreboard bench with transaction-level arbitration model and drawer.
// Revision : 1.0
// ============================================================
module tb_draw_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int XW = 9;
  localparam int YW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [XW*N-1:0] req_x;
  logic [YW*N-1:0] req_y;
  logic [N-1:0]  ack;
  logic          err;
  logic          busy;
  logic [1:0]    grant_id;
  logic          drw_start;
  logic [XW-1:0] drw_x;
  logic [YW-1:0] drw_y;
  logic          drw_done = 1'b0;

  draw_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .grant_id  (grant_id),
    .drw_start (drw_start),
    .drw_x     (drw_x),
    .drw_y     (drw_y),
    .drw_done  (drw_done)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int x; int y; int cyc; } job_t;
  typedef struct { int id; int err; int cyc; } ack_t;

  job_t job_q[$];
  ack_t ack_q[$];
  int   k_q[$];
  int   seen[$];

  int   chk_total = 0;
  int   chk_pass  = 0;
  int   cyc       = 0;
  int   forced_k  = -1;
  logic [N-1:0] keep = '0;
  bit   rand_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    chk_total++;
    if (act == exp) chk_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one job at a time, winner = first pending request
  // from the pointer; a job lasts min(k+1, TO) drive cycles plus one ack cycle.
  int ptr_m   = 0;
  int free_at = 0;
  int id_m, k_m, len_m;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      ptr_m   = 0;
      free_at = 0;
      job_q.delete();
      ack_q.delete();
      k_q.delete();
    end else if (cyc >= free_at && req != '0) begin
      id_m = -1;
      for (int s = 0; s < N; s++) begin
        if (id_m < 0 && req[(ptr_m + s) % N]) id_m = (ptr_m + s) % N;
      end
      k_m   = (forced_k >= 0) ? forced_k : int'($urandom_range(0, TO + 3));
      len_m = (k_m < TO) ? k_m + 1 : TO;
      job_q.push_back('{id_m, int'(req_x[id_m*XW +: XW]), int'(req_y[id_m*YW +: YW]), cyc});
      ack_q.push_back('{id_m, (k_m >= TO) ? 1 : 0, cyc + len_m});
      k_q.push_back(k_m);
      ptr_m   = (id_m + 1) % N;
      free_at = cyc + len_m + 2;
    end
  end

  // Drawer: pulses done in drive cycle k of each job, or never when k >= TO.
  int   dcnt = 0;
  bit   dact = 1'b0;
  logic prev_start_d = 1'b0;
  always @(negedge clk) begin
    drw_done = 1'b0;
    if (!reset_n) begin
      dact         = 1'b0;
      prev_start_d = 1'b0;
    end else begin
      if (drw_start && !prev_start_d && k_q.size() > 0) begin
        dcnt = k_q.pop_front();
        dact = (dcnt < TO);
      end
      if (dact) begin
        if (dcnt == 0) begin
          drw_done = 1'b1;
          dact     = 1'b0;
        end else begin
          dcnt--;
        end
      end
      prev_start_d = drw_start;
    end
  end

  // Monitor
  logic prev_start_m = 1'b0;
  logic prev_ack_m   = 1'b0;
  job_t cur = '{0, 0, 0, 0};
  ack_t a;
  always @(negedge clk) begin
    if (reset_n) begin
      if (drw_start && !prev_start_m) begin
        check("start_expected", (job_q.size() > 0) ? 1 : 0, 1);
        if (job_q.size() > 0) begin
          cur = job_q.pop_front();
          seen.push_back(int'(grant_id));
          check("start_grant_id", int'(grant_id), cur.id);
          check("start_drw_x", int'(drw_x), cur.x);
          check("start_drw_y", int'(drw_y), cur.y);
          check("start_cycle", cyc, cur.cyc);
        end
      end else if (drw_start) begin
        check("hold_drw_x", int'(drw_x), cur.x);
        check("hold_drw_y", int'(drw_y), cur.y);
      end
      if (ack != '0 || err) begin
        check("ack_expected", (ack_q.size() > 0) ? 1 : 0, 1);
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          check("ack_vector", int'(ack), 1 << a.id);
          check("ack_err", int'(err), a.err);
          check("ack_cycle", cyc, a.cyc);
          check("start_low_in_ack", int'(drw_start), 0);
        end
      end
      if (prev_ack_m) check("idle_after_ack", int'(busy), 0);
      prev_ack_m = (ack != '0);
    end else begin
      prev_ack_m = 1'b0;
    end
    prev_start_m = drw_start;
  end

  task automatic step();
    int j;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rand_en) keep[i] = ($urandom_range(0, 3) == 0);
      if (ack[i]) begin
        if (!keep[i]) req[i] = 1'b0;
      end else if (rand_en && !req[i] && $urandom_range(0, 5) == 0) begin
        req[i]            = 1'b1;
        req_x[i*XW +: XW] = XW'($urandom);
        req_y[i*YW +: YW] = YW'($urandom);
      end
    end
    if (rand_en && $urandom_range(0, 3) == 0) begin
      j = int'($urandom_range(0, N - 1));
      req_x[j*XW +: XW] = XW'($urandom);
      req_y[j*YW +: YW] = YW'($urandom);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while ((busy || req != '0) && n < max_cyc) begin
      step();
      n++;
    end
    check({"drained_", tag}, (busy || req != '0) ? 1 : 0, 0);
  endtask

  task automatic wait_acks(input int want, input int max_cyc, input string tag);
    int got = 0;
    int n   = 0;
    while (got < want && n < max_cyc) begin
      step();
      if (ack != '0) got++;
      n++;
    end
    check({"acks_", tag}, got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int drive_cnt;
    reset_n = 1'b0;
    req     = '0;
    req_x   = '0;
    req_y   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_drw_start", int'(drw_start), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    check("rst_drw_x", int'(drw_x), 0);
    check("rst_drw_y", int'(drw_y), 0);
    check("rst_grant_id", int'(grant_id), 0);
    reset_n = 1'b1;
    step();

    // Single request, latency and latched coordinates
    forced_k          = 2;
    req_x[2*XW +: XW] = 9'd10;
    req_y[2*YW +: YW] = 8'd20;
    req[2]            = 1'b1;
    step();
    check("d1_drw_start", int'(drw_start), 1);
    check("d1_drw_x", int'(drw_x), 10);
    check("d1_drw_y", int'(drw_y), 20);
    check("d1_grant_id", int'(grant_id), 2);
    req_x[2*XW +: XW] = 9'd300;
    req_y[2*YW +: YW] = 8'd99;
    step();
    check("d1_x_after_change", int'(drw_x), 10);
    wait_idle(40, "d1");

    // Reset in the middle of a job
    forced_k          = 99;
    req_x[1*XW +: XW] = 9'd77;
    req_y[1*YW +: YW] = 8'd33;
    req[1]            = 1'b1;
    step(); step(); step();
    check("d3_busy_before_reset", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("d3_rst_drw_start", int'(drw_start), 0);
    check("d3_rst_busy", int'(busy), 0);
    check("d3_rst_ack", int'(ack), 0);
    check("d3_rst_err", int'(err), 0);
    check("d3_rst_drw_x", int'(drw_x), 0);
    check("d3_rst_drw_y", int'(drw_y), 0);
    step(); step();
    req_x[3*XW +: XW] = 9'd400;
    req_y[3*YW +: YW] = 8'd200;
    req[3]            = 1'b1;
    forced_k          = 1;
    reset_n           = 1'b1;
    base = seen.size();
    step();
    check("d3_first_grant", int'(grant_id), 1);
    wait_idle(80, "d3");
    check("d3_jobs", seen.size() - base, 2);
    if (seen.size() - base == 2) check("d3_second_grant", seen[base+1], 3);

    // All four requesting from reset
    reset_n  = 1'b0;
    forced_k = -1;
    for (int i = 0; i < N; i++) begin
      req_x[i*XW +: XW] = XW'(50 * i + 5);
      req_y[i*YW +: YW] = YW'(40 * i + 7);
    end
    req = '1;
    step(); step();
    reset_n = 1'b1;
    base = seen.size();
    wait_idle(200, "d2");
    check("d2_jobs", seen.size() - base, 4);
    if (seen.size() - base == 4) begin
      for (int i = 0; i < 4; i++) check("d2_order", seen[base+i], i);
    end

    // Two requesters held continuously alternate
    keep   = 4'b1001;
    req[0] = 1'b1;
    req[3] = 1'b1;
    base   = seen.size();
    wait_acks(4, 200, "d4");
    keep = '0;
    wait_idle(100, "d4");
    if (seen.size() - base >= 4) begin
      check("d4_g0", seen[base], 0);
      check("d4_g1", seen[base+1], 3);
      check("d4_g2", seen[base+2], 0);
      check("d4_g3", seen[base+3], 3);
    end else begin
      check("d4_jobs", seen.size() - base, 4);
    end

    // Drawer never completes: timeout
    forced_k          = 99;
    req_x[0*XW +: XW] = 9'd123;
    req_y[0*YW +: YW] = 8'd45;
    req[0]            = 1'b1;
    drive_cnt = 0;
    n         = 0;
    step();
    while (ack == '0 && n < 40) begin
      if (drw_start) drive_cnt++;
      step();
      n++;
    end
    check("d5_ack", int'(ack), 1);
    check("d5_err", int'(err), 1);
    check("d5_drive_cycles", drive_cnt, TO);
    step();
    check("d5_busy_after", int'(busy), 0);
    wait_idle(40, "d5");

    // Randomized traffic
    forced_k = -1;
    rand_en  = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    keep    = '0;
    wait_idle(400, "rand");

    check("job_q_empty", job_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one shape drawer.
REQ-002 Parameter TIMEOUT, default 16, max DRIVE cycles allowed before abort.
REQ-003 clk  input  1  the single clock, rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-requester draw request level, held until acked.
REQ-006 req_x  input  9*N_REQ  packed x coordinates, slice i belongs to requester i.
REQ-007 req_y  input  8*N_REQ  packed y coordinates, slice i belongs to requester i.
REQ-008 ack  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-009 err  output  1  one-cycle pulse, coincident with ack, when the job timed out.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  clog2(N_REQ)  index of the requester currently being served.
REQ-012 drw_start  output  1  start level to the shape drawer.
REQ-013 drw_x  output  9  x origin to the drawer; drw_y output 8 y origin to the drawer.
REQ-014 drw_done  input  1  drawer completion pulse.

Function
REQ-015 FSM states: IDLE, DRIVE, ACK; register-based, with next-state logic separate from the state register.
REQ-016 IDLE: if any req bit is high, select the winner by round-robin starting at rr_ptr, latch grant_id, its x and y slices, clear the timeout counter, and go to DRIVE; otherwise stay in IDLE.
REQ-017 Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ; on leaving ACK, rr_ptr = grant_id+1 mod N_REQ.
REQ-018 DRIVE: drw_start=1, drw_x/drw_y = latched values; later changes on req_x/req_y SHALL NOT affect the job in flight.
REQ-019 DRIVE: on drw_done=1 go to ACK with err=0; the timeout counter increments every DRIVE cycle.
REQ-020 DRIVE: if the counter reaches TIMEOUT-1 with drw_done=0, go to ACK with err flagged; drw_done on that same cycle counts as success.
REQ-021 ACK: drw_start=0 (releases the drawer from FINISH), ack[grant_id]=1, err=1 iff timed out, then IDLE unconditionally.
REQ-022 drw_start SHALL be low in IDLE and ACK, guaranteeing one low cycle between jobs.
REQ-023 Requesters drop req the cycle after ack; if req stays high, it re-enters arbitration at the lowest priority.
REQ-024 With a compliant drawer, latency is req high to drw_start high = 1 cycle, and drw_done to ack = 1 cycle.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, rr_ptr=0, counter=0, latched coordinates=0, and grant_id=0.
REQ-026 While in reset, ack, err, busy, drw_start, drw_x and drw_y SHALL be 0, including reset asserted mid-DRIVE.

Structure
REQ-027 A shared package draw_pkg SHALL hold the state enum (3-bit, default X for illegal), coordinate widths (X_W=9, Y_W=8) and the TIMEOUT default.
REQ-028 One sub-module rr_picker (combinational: req vector and pointer in, one-hot grant and valid out) SHALL implement the selection.

Verification
REQ-029 req=0100, x2=10, y2=20 -> next cycle drw_start=1, drw_x=10, drw_y=20, grant_id=2; ack=0100 one cycle after drw_done.
REQ-030 req=1111 held from reset, each dropped after its ack -> service order 0,1,2,3, with drw_start low one cycle between each job.
REQ-031 req0 and req3 held continuously -> grants alternate 0,3,0,3.
REQ-032 drw_done tied 0, req=0001 -> after 16 DRIVE cycles, ack=0001 and err=1 together, then busy=0.
REQ-033 reset_n pulled low during DRIVE -> drw_start and busy drop immediately; after release, the first grant follows rr_ptr=0.
REQ-034 req_x changed while in DRIVE -> drw_x holds the latched value until ACK.
